wrr_link_arbiter: RTL and testbench

- Weighted round-robin arbiter sharing one deflection-network output link among N requesters (local inject port plus bypass lanes).
- Per-requester weights come from a packed 32-bit-per-entry parameter array, in the same style as the network's per-lane configuration arrays.
- Grants use a valid/ready handshake. The winner's flit is captured into a single registered output stage that drives the link.

---
 rtl/wrr_link_arbiter_if.sv | 25 ++
 rtl/wrr_link_arbiter.sv | 87 ++++++++
 tb/tb_wrr_link_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/wrr_link_arbiter_if.sv
// Handshake bundle between the requesters, the weighted round-robin arbiter and the
// output link: per-requester valid/data/ready in, one registered flit out.
interface wrr_link_arbiter_if #(
    parameter int N   = 4,
    parameter int D   = 32,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]   in_valid;
    logic [N*D-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [D-1:0]   out_data;
    logic [IDW-1:0] out_id;
    logic           out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_id
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/wrr_link_arbiter.sv
// Weighted round-robin arbiter sharing one deflection-network output link among N
// requesters; the winning flit is captured into a single registered output stage.
module wrr_link_arbiter #(
    parameter int              N       = 4,
    parameter int              D       = 32,
    parameter logic [N*32-1:0] WEIGHTS = {32'd1, 32'd1, 32'd1, 32'd1},
    localparam int             IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    wrr_link_arbiter_if.slave link
);

    logic [31:0]    weight [N];
    logic [N-1:0]   en;
    logic [IDW-1:0] ptr;
    logic [31:0]    credit;
    logic           out_valid_q;
    logic [D-1:0]   out_data_q;
    logic [IDW-1:0] out_id_q;
    logic           load;
    logic           have_cand;
    logic [IDW-1:0] cand;
    logic [N-1:0]   ready;

    for (genvar g = 0; g < N; g++) begin : g_weight
        assign weight[g] = WEIGHTS[32*g +: 32];
        assign en[g]     = |weight[g];
    end

    assign load = !out_valid_q || link.out_ready;

    // The holder keeps the link while it has credit; otherwise scan from ptr+1,
    // visiting ptr itself last so a lone requester can re-win with a fresh reload.
    always_comb begin
        have_cand = 1'b0;
        cand      = '0;
        if (load && !rst) begin
            if (credit != 32'd0 && link.in_valid[ptr] && en[ptr]) begin
                have_cand = 1'b1;
                cand      = ptr;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    if (!have_cand && link.in_valid[(int'(ptr) + k) % N]
                                   && en[(int'(ptr) + k) % N]) begin
                        have_cand = 1'b1;
                        cand      = IDW'((int'(ptr) + k) % N);
                    end
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        if (have_cand) ready[cand] = 1'b1;
    end

    assign link.in_ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            ptr         <= IDW'(N - 1);
            credit      <= '0;
        end else if (have_cand) begin
            out_valid_q <= 1'b1;
            out_data_q  <= link.in_data[D*int'(cand) +: D];
            out_id_q    <= cand;
            if (cand == ptr && credit != 32'd0) begin
                credit <= credit - 32'd1;
            end else begin
                ptr    <= cand;
                credit <= weight[cand] - 32'd1;
            end
        end else if (load) begin
            out_valid_q <= 1'b0;
        end
    end

    assign link.out_valid = out_valid_q;
    assign link.out_data  = out_data_q;
    assign link.out_id    = out_id_q;

endmodule

// File: tb/tb_wrr_link_arbiter.sv
// Directed bench for wrr_link_arbiter: three instances with equal, skewed and
// zero-containing weights share one stimulus set.
module tb_wrr_link_arbiter;
    localparam int N = 4;
    localparam int D = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [N*D-1:0] data;
    logic           oready;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    wrr_link_arbiter_if #(.N(N), .D(D)) ifa ();
    wrr_link_arbiter_if #(.N(N), .D(D)) ifb ();
    wrr_link_arbiter_if #(.N(N), .D(D)) ifc ();

    assign ifa.in_valid = valid;
    assign ifa.in_data = data;
    assign ifa.out_ready = oready;
    assign ifb.in_valid = valid;
    assign ifb.in_data = data;
    assign ifb.out_ready = oready;
    assign ifc.in_valid = valid;
    assign ifc.in_data = data;
    assign ifc.out_ready = oready;

    wrr_link_arbiter #(.N(N), .D(D), .WEIGHTS({32'd1, 32'd1, 32'd1, 32'd1}))
        dut_a (.clk(clk), .rst(rst), .link(ifa));
    wrr_link_arbiter #(.N(N), .D(D), .WEIGHTS({32'd1, 32'd1, 32'd1, 32'd3}))
        dut_b (.clk(clk), .rst(rst), .link(ifb));
    wrr_link_arbiter #(.N(N), .D(D), .WEIGHTS({32'd1, 32'd0, 32'd1, 32'd1}))
        dut_c (.clk(clk), .rst(rst), .link(ifc));

    task automatic next_cycle;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        valid  = '0;
        oready = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        valid  = 4'b1111;
        oready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (ifa.in_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL reset_in_ready cyc%0d got=%b exp=0000", i, ifa.in_ready);
            end
            checks++;
            if (ifa.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_out_valid cyc%0d got=%b exp=0", i, ifa.out_valid);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ifa.in_ready !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL release_in_ready got=%b exp=0001", ifa.in_ready);
        end
        next_cycle();
        checks++;
        if (ifa.out_valid !== 1'b1 || ifa.out_id !== 2'd0) begin
            errors++;
            $display("[TB] FAIL release_first_flit got valid=%b id=%0d exp valid=1 id=0",
                     ifa.out_valid, ifa.out_id);
        end
    endtask

    task automatic test_equal_weights;
        int exp_ids[6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        valid = 4'b1111;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_id !== 2'(exp_ids[i])
                || ifa.out_data !== 32'hF00D0000 + 32'(exp_ids[i])) begin
                errors++;
                $display("[TB] FAIL equal_seq[%0d] got valid=%b id=%0d data=%h exp id=%0d",
                         i, ifa.out_valid, ifa.out_id, ifa.out_data, exp_ids[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_weighted;
        int exp_ids[10] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
        do_reset();
        valid = 4'b1111;
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (ifb.out_valid !== 1'b1 || ifb.out_id !== 2'(exp_ids[i])
                || ifb.out_data !== 32'hF00D0000 + 32'(exp_ids[i])) begin
                errors++;
                $display("[TB] FAIL weighted_seq[%0d] got valid=%b id=%0d data=%h exp id=%0d",
                         i, ifb.out_valid, ifb.out_id, ifb.out_data, exp_ids[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        int exp_ids[3] = '{2, 3, 0};
        do_reset();
        valid = 4'b1111;
        next_cycle();
        next_cycle();
        oready = 1'b0;
        #1;
        checks++;
        if (ifa.in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stall_entry_in_ready got=%b exp=0000", ifa.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_id !== 2'd1
                || ifa.out_data !== 32'hF00D0001 || ifa.in_ready !== 4'b0000) begin
                errors++;
                $display("[TB] FAIL stall_hold[%0d] got valid=%b id=%0d data=%h rdy=%b exp id=1 data=f00d0001 rdy=0000",
                         i, ifa.out_valid, ifa.out_id, ifa.out_data, ifa.in_ready);
            end
        end
        oready = 1'b1;
        #1;
        checks++;
        if (ifa.in_ready !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL resume_in_ready got=%b exp=0100", ifa.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (ifa.out_valid !== 1'b1 || ifa.out_id !== 2'(exp_ids[i])
                || ifa.out_data !== 32'hF00D0000 + 32'(exp_ids[i])) begin
                errors++;
                $display("[TB] FAIL resume_seq[%0d] got id=%0d data=%h exp id=%0d",
                         i, ifa.out_id, ifa.out_data, exp_ids[i]);
            end
        end
    endtask

    task automatic test_zero_weight;
        int exp_ids[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        valid = 4'b1111;
        next_cycle();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_id !== 2'(exp_ids[i]) || ifc.in_ready[2] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL zero_weight_seq[%0d] got id=%0d rdy=%b exp id=%0d rdy2=0",
                         i, ifc.out_id, ifc.in_ready, exp_ids[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_drop_valid;
        int exp_ids[7] = '{1, 2, 3, 0, 0, 0, 1};
        do_reset();
        valid = 4'b1111;
        next_cycle();
        checks++;
        if (ifb.out_id !== 2'd0 || ifb.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL drop_first got id=%0d valid=%b exp id=0 valid=1",
                     ifb.out_id, ifb.out_valid);
        end
        valid = 4'b1110;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            if (i == 2) valid = 4'b1111;
            checks++;
            if (ifb.out_valid !== 1'b1 || ifb.out_id !== 2'(exp_ids[i])) begin
                errors++;
                $display("[TB] FAIL drop_seq[%0d] got id=%0d valid=%b exp id=%0d",
                         i, ifb.out_id, ifb.out_valid, exp_ids[i]);
            end
        end
    endtask

    task automatic test_idle;
        valid = '0;
        next_cycle();
        next_cycle();
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_drain got valid=%b rdy=%b exp valid=0 rdy=0000",
                     ifa.out_valid, ifa.in_ready);
        end
    endtask

    initial begin
        data = {32'hF00D0003, 32'hF00D0002, 32'hF00D0001, 32'hF00D0000};
        test_reset();
        test_equal_weights();
        test_weighted();
        test_back_to_back();
        test_zero_weight();
        test_drop_valid();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
